sha256_nonce_scheduler: RTL and testbench
=========================================

Name: sha256_nonce_scheduler

Overview:
- Sequencing controller for the SHA-256d mining datapath. Latches one work unit (midstate plus 96-bit block tail).
- Builds the padded 512-bit second block with an incrementing nonce.
- Drives cnt/feedback for LOOP-folded sha256_transform instances.
- Checks each returned final hash and reports golden nonces, with per-work busy/done status for the host interface.

Parameters:
- LOOP, 1, transform fold factor; one nonce issued every LOOP cycles; legal 1,2,4,8,16,32,64.
- NONCE_OFFSET, 136, number of nonce steps between issuing a nonce on tx_input and its final hash being valid on hash_in at a sample point; must be >=1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- work_valid  in  1  single-cycle strobe; load new work
- work_midstate  in  256  midstate for first transform
- work_data  in  96  last 12 bytes of header (merkle tail, time, bits)
- nonce_start  in  32  first nonce of range
- nonce_end  in  32  last nonce of range, inclusive
- hash_in  in  256  final SHA-256d result from downstream transform
- cnt  out  6  fold phase to transforms
- feedback  out  1  transform feedback select
- tx_state  out  256  registered midstate
- tx_input  out  512  registered padded block
- golden_valid  out  1  one-cycle pulse, hit found
- golden_nonce  out  32  nonce of latest hit; holds until next hit
- busy  out  1  high in FILL/RUN
- done  out  1  one-cycle pulse, range fully checked

Behaviour:
- Reset (async, applies mid-operation too): state IDLE. All outputs 0: cnt=0, feedback=0, tx_state=0, tx_input=0, golden_valid=0, golden_nonce=0, busy=0, done=0.
- Phase counter: cnt runs 0..LOOP-1 and wraps; free-runs in FILL/RUN, held 0 otherwise. feedback = (cnt != 0). A "step" is a cycle with cnt == LOOP-1 (every cycle when LOOP=1).
- tx_input layout, word k = bits [32k+31:32k]:
  - W0..W2 = work_data[31:0], [63:32], [95:64]
  - W3 = issue nonce
  - W4 = 32'h80000000
  - W5..W14 = 0
  - W15 = 32'h00000280
- States:
  - IDLE: wait for work_valid.
  - FILL: issue_nonce advances each step; fill counter counts NONCE_OFFSET steps; then go to RUN. No hash checks.
  - RUN: at each step, sample hash_in and test check_nonce, then increment check_nonce. After testing check_nonce == nonce_end, go to DONE.
  - DONE: done pulses for one cycle, then IDLE; registers hold their values.
- work_valid in any state: latch midstate and data into tx_state/tx_input next cycle. issue_nonce = check_nonce = nonce_start, cnt=0, fill counter cleared, enter FILL. This aborts the current range with no done pulse. A hit in the same cycle is discarded.
- issue_nonce saturates at nonce_end; it does not wrap. It increments at a step only while below nonce_end.
- nonce_end < nonce_start: the range wraps through 0xFFFFFFFF -> 0. Comparisons are equality only, and 32-bit arithmetic is modulo 2^32.
- Hit condition: hash_in[255:224] == 0 at a RUN step. golden_nonce <= check_nonce; golden_valid pulses the next cycle.
- Hits are only possible at steps, so at most one hit per LOOP cycles.
- Latency: work_valid to first tx_input update is 1 cycle. Hit sample to golden_valid is 1 cycle.

Optional Feature:
- Macro GOLDEN_FIFO_EN.
- Defined:
  - Adds a 4-entry golden nonce FIFO and input port golden_ready.
  - golden_valid means the FIFO is non-empty; golden_nonce shows the head entry; pop on golden_valid && golden_ready.
  - On push while full, the newest hit is dropped and the sticky output overflow (1 bit, cleared by reset or work_valid) is set.
  - Simultaneous push and pop while full succeeds.
  - work_valid does not flush the FIFO.
- Undefined: single register, pulse semantics as above. golden_ready and overflow are absent.

Decomposition:
- Package sha256_miner_pkg: W4/W15 padding constants, state enum (IDLE, FILL, RUN, DONE), word-index helper.
- One sub-module, golden_nonce_fifo (depth 4, width 32), instantiated only under GOLDEN_FIFO_EN.

Test Plan:
- LOOP=1, NONCE_OFFSET=3, range 0x10..0x14, hash_in top word never 0 -> busy high 8 cycles, tx_input W3 sequence 0x10..0x14 then held, done pulse once, no golden.
- Same setup, hash_in[255:224]=0 forced at the 2nd RUN step -> golden_valid pulse, golden_nonce=0x11.
- LOOP=4: cnt sequence 0,1,2,3,0; feedback 0,1,1,1,0; nonce advances every 4 cycles. Zero hash on non-step cycles -> ignored.
- Range 0xFFFFFFFE..0x00000001 -> W3 sequence FFFFFFFE, FFFFFFFF, 0, 1, and done after 4 checks.
- work_valid mid-RUN, then reset asserted mid-FILL -> restart at the new nonce_start with no done; on reset, all outputs 0 immediately, asynchronously.
- GOLDEN_FIFO_EN, golden_ready=0, 5 hits -> 4 queued, overflow=1; pops return nonces in order.

Source files
------------

// File: rtl/sha256_miner_pkg.sv
// Shared widths, SHA-256 padding words, scheduler state encoding and block word helper
// for the SHA-256d nonce scheduler.
package sha256_miner_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned DATA_W  = 96;
  localparam int unsigned HASH_W  = 256;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned CNT_W   = 6;

  // Second-block padding for an 80-byte header: 0x80 marker, then 640-bit length
  localparam logic [WORD_W-1:0] PAD_W4  = 32'h8000_0000;
  localparam logic [WORD_W-1:0] PAD_W15 = 32'h0000_0280;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  function automatic int unsigned word_lsb(input int unsigned k);
    return k * WORD_W;
  endfunction

endpackage

// File: rtl/sha256_nonce_scheduler_if.sv
// Host-side work/result bus of the nonce scheduler. GOLDEN_FIFO_EN adds
// golden_ready and the sticky overflow flag.
interface sha256_nonce_scheduler_if;
  import sha256_miner_pkg::*;

  logic               work_valid;
  logic [HASH_W-1:0]  work_midstate;
  logic [DATA_W-1:0]  work_data;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_end;
  logic               golden_valid;
  logic [NONCE_W-1:0] golden_nonce;
  logic               busy;
  logic               done;
`ifdef GOLDEN_FIFO_EN
  logic               golden_ready;
  logic               overflow;
`endif

  modport master (
`ifdef GOLDEN_FIFO_EN
    output golden_ready,
    input  overflow,
`endif
    output work_valid, work_midstate, work_data, nonce_start, nonce_end,
    input  golden_valid, golden_nonce, busy, done
  );

  modport slave (
`ifdef GOLDEN_FIFO_EN
    input  golden_ready,
    output overflow,
`endif
    input  work_valid, work_midstate, work_data, nonce_start, nonce_end,
    output golden_valid, golden_nonce, busy, done
  );

endinterface

// File: rtl/golden_nonce_fifo.sv
// Small FIFO queuing golden nonces for the host; only built with GOLDEN_FIFO_EN.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
`ifdef GOLDEN_FIFO_EN
module golden_nonce_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push_c, do_pop_c;

  always_comb begin
    do_pop_c  = pop && valid;
    do_push_c = push && (!full || do_pop_c);
    occ_d     = occ_q;
    if (do_push_c && !do_pop_c)      occ_d = occ_q + OCC_W'(1);
    else if (do_pop_c && !do_push_c) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
      valid <= (occ_d != '0);
      full  <= (occ_d == OCC_W'(DEPTH));
    end
  end

  assign dout = mem_q[rd_ptr_q];

endmodule
`endif

// File: rtl/sha256_nonce_scheduler.sv
// Work latch, padded-block builder and IDLE/FILL/RUN/DONE sequencer for LOOP-folded
// SHA-256d transforms. Define GOLDEN_FIFO_EN to queue hits in golden_nonce_fifo.
module sha256_nonce_scheduler
  import sha256_miner_pkg::*;
#(
  parameter int unsigned LOOP         = 1,
  parameter int unsigned NONCE_OFFSET = 136
) (
  input  logic                      clk,
  input  logic                      reset,
  sha256_nonce_scheduler_if.slave   host,
  input  logic [HASH_W-1:0]         hash_in,
  output logic [CNT_W-1:0]          cnt,
  output logic                      feedback,
  output logic [HASH_W-1:0]         tx_state,
  output logic [BLOCK_W-1:0]        tx_input
);

  sched_state_e       state_q, state_d;
  logic [NONCE_W-1:0] issue_q, issue_d, check_q, check_d, end_q, end_d;
  logic [31:0]        fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [HASH_W-1:0]  tx_state_d;
  logic [BLOCK_W-1:0] tx_input_d;
  logic               step_c, hit_c, running_c;
  logic               unused_hash_low;

  // Only the top word of the final hash decides a hit
  assign unused_hash_low = ^hash_in[HASH_W-WORD_W-1:0];
  assign step_c          = (cnt == CNT_W'(LOOP - 1));
  assign running_c       = (state_q == FILL) || (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    issue_d    = issue_q;
    check_d    = check_q;
    end_d      = end_q;
    fill_d     = fill_q;
    cnt_d      = '0;
    tx_state_d = tx_state;
    tx_input_d = tx_input;
    hit_c      = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      FILL: begin
        if (step_c) begin
          if (issue_q != end_q) issue_d = issue_q + NONCE_W'(1);
          if (fill_q == 32'(NONCE_OFFSET - 1)) begin
            state_d = RUN;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + 32'd1;
          end
        end
      end
      RUN: begin
        if (step_c) begin
          if (issue_q != end_q) issue_d = issue_q + NONCE_W'(1);
          hit_c   = (hash_in[HASH_W-1 -: WORD_W] == '0);
          check_d = check_q + NONCE_W'(1);
          if (check_q == end_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (running_c) cnt_d = step_c ? '0 : cnt + CNT_W'(1);

    // New work aborts whatever is in flight, including a same-cycle hit
    if (host.work_valid) begin
      state_d    = FILL;
      issue_d    = host.nonce_start;
      check_d    = host.nonce_start;
      end_d      = host.nonce_end;
      fill_d     = '0;
      cnt_d      = '0;
      hit_c      = 1'b0;
      tx_state_d = host.work_midstate;
      tx_input_d = '0;
      tx_input_d[word_lsb(0) +: WORD_W]  = host.work_data[31:0];
      tx_input_d[word_lsb(1) +: WORD_W]  = host.work_data[63:32];
      tx_input_d[word_lsb(2) +: WORD_W]  = host.work_data[95:64];
      tx_input_d[word_lsb(4) +: WORD_W]  = PAD_W4;
      tx_input_d[word_lsb(15) +: WORD_W] = PAD_W15;
    end

    tx_input_d[word_lsb(3) +: WORD_W] = issue_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      issue_q   <= '0;
      check_q   <= '0;
      end_q     <= '0;
      fill_q    <= '0;
      cnt       <= '0;
      feedback  <= 1'b0;
      tx_state  <= '0;
      tx_input  <= '0;
      host.busy <= 1'b0;
      host.done <= 1'b0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      check_q   <= check_d;
      end_q     <= end_d;
      fill_q    <= fill_d;
      cnt       <= cnt_d;
      feedback  <= (cnt_d != '0);
      tx_state  <= tx_state_d;
      tx_input  <= tx_input_d;
      host.busy <= (state_d == FILL) || (state_d == RUN);
      host.done <= (state_d == DONE);
    end
  end

`ifdef GOLDEN_FIFO_EN
  logic fifo_full, fifo_pop_c;

  assign fifo_pop_c = host.golden_valid && host.golden_ready;

  golden_nonce_fifo #(
    .DEPTH (4),
    .WIDTH (NONCE_W)
  ) u_golden_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hit_c),
    .pop   (fifo_pop_c),
    .din   (check_q),
    .dout  (host.golden_nonce),
    .valid (host.golden_valid),
    .full  (fifo_full)
  );

  // Sticky drop flag; a pop in the same cycle makes room for the hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                host.overflow <= 1'b0;
    else if (host.work_valid) host.overflow <= 1'b0;
    else if (hit_c && fifo_full && !fifo_pop_c) host.overflow <= 1'b1;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host.golden_valid <= 1'b0;
      host.golden_nonce <= '0;
    end else begin
      host.golden_valid <= hit_c;
      if (hit_c) host.golden_nonce <= check_q;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Scoreboard bench for sha256_nonce_scheduler: instance A (LOOP=1, NONCE_OFFSET=3) and
// instance B (LOOP=4, NONCE_OFFSET=2); FIFO checks compile in with GOLDEN_FIFO_EN.
module tb_sha256_nonce_scheduler;

  localparam int unsigned NO_A   = 3;
  localparam int unsigned NO_B   = 2;
  localparam int unsigned LOOP_B = 4;
  localparam logic [255:0] MID   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [95:0]  DATA  = 96'h0badcafe_12345678_deadbeef;
  localparam logic [255:0] HIT   = {32'h0, {224{1'b1}}};
  localparam logic [255:0] MISS  = {32'h1, 224'h0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] hash_a, hash_b;
  logic [5:0]   cnt_a, cnt_b;
  logic         fb_a, fb_b;
  logic [255:0] txs_a, txs_b;
  logic [511:0] txi_a, txi_b;

  sha256_nonce_scheduler_if ia();
  sha256_nonce_scheduler_if ib();

  sha256_nonce_scheduler #(.LOOP(1), .NONCE_OFFSET(NO_A)) dut_a (
    .clk(clk), .reset(reset), .host(ia), .hash_in(hash_a),
    .cnt(cnt_a), .feedback(fb_a), .tx_state(txs_a), .tx_input(txi_a)
  );

  sha256_nonce_scheduler #(.LOOP(LOOP_B), .NONCE_OFFSET(NO_B)) dut_b (
    .clk(clk), .reset(reset), .host(ib), .hash_in(hash_b),
    .cnt(cnt_b), .feedback(fb_b), .tx_state(txs_b), .tx_input(txi_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] qa_g[$];
  logic [31:0] qb_g[$];
  int qa_d = 0;
  int qb_d = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic pop_a, pop_b;
`ifdef GOLDEN_FIFO_EN
  assign pop_a = ia.golden_valid && ia.golden_ready;
  assign pop_b = ib.golden_valid && ib.golden_ready;
`else
  assign pop_a = ia.golden_valid;
  assign pop_b = ib.golden_valid;
`endif

  // Monitors: every result the DUT presents must match the next queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (pop_a) begin
        chk("a_golden_expected", 256'(qa_g.size() != 0), 256'(1));
        if (qa_g.size() != 0) chk("a_golden_nonce", 256'(ia.golden_nonce), 256'(qa_g.pop_front()));
      end
      if (ia.done) begin
        chk("a_done_expected", 256'(qa_d > 0), 256'(1));
        if (qa_d > 0) qa_d--;
      end
      if (pop_b) begin
        chk("b_golden_expected", 256'(qb_g.size() != 0), 256'(1));
        if (qb_g.size() != 0) chk("b_golden_nonce", 256'(ib.golden_nonce), 256'(qb_g.pop_front()));
      end
      if (ib.done) begin
        chk("b_done_expected", 256'(qb_d > 0), 256'(1));
        if (qb_d > 0) qb_d--;
      end
    end
  end

  task automatic check_reset_a(input string tag);
    chk({tag, "_cnt"}, 256'(cnt_a), 256'(0));
    chk({tag, "_feedback"}, 256'(fb_a), 256'(0));
    chk({tag, "_tx_state"}, txs_a, 256'(0));
    chk({tag, "_tx_input_any"}, 256'(|txi_a), 256'(0));
    chk({tag, "_golden_valid"}, 256'(ia.golden_valid), 256'(0));
    chk({tag, "_golden_nonce"}, 256'(ia.golden_nonce), 256'(0));
    chk({tag, "_busy_done"}, 256'({ia.busy, ia.done}), 256'(0));
  endtask

  task automatic load_a(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    ia.work_midstate = MID;
    ia.work_data     = DATA;
    ia.nonce_start   = s;
    ia.nonce_end     = e;
    ia.work_valid    = 1'b1;
    @(negedge clk);
    ia.work_valid = 1'b0;
  endtask

  // hit_j: -1 no hit, >=0 hit at that RUN step, -2 hit at every RUN step
  task automatic run_a(input logic [31:0] s, input logic [31:0] e, input int hit_j, input int n);
    int          busy_cyc = 0;
    logic [31:0] w3 = s;
    hash_a = MISS;
    load_a(s, e);
    chk("a_tx_state_latch", txs_a, MID);
    chk("a_w0", 256'(txi_a[31:0]), 256'(32'hdeadbeef));
    chk("a_w2", 256'(txi_a[95:64]), 256'(32'h0badcafe));
    chk("a_w4", 256'(txi_a[159:128]), 256'(32'h80000000));
    chk("a_w5_w14_zero", 256'(|txi_a[479:160]), 256'(0));
    chk("a_w15", 256'(txi_a[511:480]), 256'(32'h00000280));
    for (int k = 0; k < int'(NO_A) + n + 4; k++) begin
      if (k != 0) @(negedge clk);
      if (hit_j == -2) hash_a = (k >= int'(NO_A)) ? HIT : MISS;
      else             hash_a = (hit_j >= 0 && k == int'(NO_A) + hit_j) ? HIT : MISS;
      if (ia.busy) busy_cyc++;
      chk("a_w3_nonce", 256'(txi_a[127:96]), 256'(w3));
      if (w3 != e) w3 = w3 + 32'd1;
    end
    hash_a = MISS;
    chk("a_busy_cycles", 256'(busy_cyc), 256'(int'(NO_A) + n));
  endtask

  task automatic run_b();
    int busy_cyc = 0;
    hash_b = HIT;
    @(negedge clk);
    ib.work_midstate = MID;
    ib.work_data     = DATA;
    ib.nonce_start   = 32'h20;
    ib.nonce_end     = 32'h21;
    ib.work_valid    = 1'b1;
    @(negedge clk);
    ib.work_valid = 1'b0;
    // Zero hash everywhere except the first RUN step (edge 12): off-step zeros must be ignored
    for (int k = 0; k < 21; k++) begin
      if (k != 0) @(negedge clk);
      hash_b = (k + 1 == 12) ? MISS : HIT;
      if (ib.busy) busy_cyc++;
      if (k <= 8) begin
        chk("b_cnt", 256'(cnt_b), 256'(k % 4));
        chk("b_feedback", 256'(fb_b), 256'((k % 4) != 0));
      end
      chk("b_w3_nonce", 256'(txi_b[127:96]), 256'((k < 4) ? 32'h20 : 32'h21));
    end
    hash_b = MISS;
    chk("b_busy_cycles", 256'(busy_cyc), 256'(16));
  endtask

  initial begin
    ia.work_valid = 1'b0; ia.work_midstate = '0; ia.work_data = '0;
    ia.nonce_start = '0; ia.nonce_end = '0;
    ib.work_valid = 1'b0; ib.work_midstate = '0; ib.work_data = '0;
    ib.nonce_start = '0; ib.nonce_end = '0;
`ifdef GOLDEN_FIFO_EN
    ia.golden_ready = 1'b1;
    ib.golden_ready = 1'b1;
`endif
    hash_a = MISS;
    hash_b = MISS;
    #1;
    check_reset_a("a_reset");
    chk("b_reset_cnt_busy", 256'({cnt_b, ib.busy}), 256'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Plain range, no hits
    qa_d++;
    run_a(32'h10, 32'h14, -1, 5);

    // Hit on the second RUN step
    qa_g.push_back(32'h11); qa_d++;
    run_a(32'h10, 32'h14, 1, 5);

    // Range wrapping through 0xFFFFFFFF
    qa_d++;
    run_a(32'hFFFF_FFFE, 32'h0000_0001, -1, 4);

    // Folded instance: hit only at the final step
    qb_g.push_back(32'h21); qb_d++;
    run_b();

    // Abort mid-RUN with new work, then async reset mid-FILL; no done expected
    load_a(32'h40, 32'h60);
    repeat (5) @(negedge clk);
    load_a(32'h100, 32'h102);
    chk("a_restart_w3", 256'(txi_a[127:96]), 256'(32'h100));
    chk("a_restart_busy", 256'(ia.busy), 256'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_a("a_async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("a_idle_after_reset", 256'(ia.busy), 256'(0));

    qa_g.push_back(32'h200); qa_d++;
    run_a(32'h200, 32'h201, 0, 2);

`ifdef GOLDEN_FIFO_EN
    // Five hits with no consumer: four queue, fifth is dropped
    ia.golden_ready = 1'b0;
    for (int i = 0; i < 4; i++) qa_g.push_back(32'h30 + 32'(i));
    qa_d++;
    run_a(32'h30, 32'h34, -2, 5);
    chk("a_fifo_overflow", 256'(ia.overflow), 256'(1));
    chk("a_fifo_valid", 256'(ia.golden_valid), 256'(1));
    chk("a_fifo_head", 256'(ia.golden_nonce), 256'(32'h30));
    @(negedge clk);
    ia.golden_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("a_fifo_drained", 256'(ia.golden_valid), 256'(0));
    chk("a_fifo_overflow_sticky", 256'(ia.overflow), 256'(1));
`endif

    repeat (4) @(negedge clk);
    chk("a_golden_queue_empty", 256'(qa_g.size()), 256'(0));
    chk("a_done_all_seen", 256'(qa_d), 256'(0));
    chk("b_golden_queue_empty", 256'(qb_g.size()), 256'(0));
    chk("b_done_all_seen", 256'(qb_d), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
